// File: rtl/load_unit_pkg.sv
// Shared definitions for the load/store datapath: opcodes, instruction field
// positions, FSM state encoding and alignment helpers.
package load_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WB,
        ERR
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Bytes are always aligned; halfwords need addr[0]==0, words addr[1:0]==0.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LW:         return off != 2'b00;
            OP_LH, OP_LHU: return off[0];
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_extend.sv
// Combinational lane select and sign/zero extension of a little-endian memory
// word; shared with any future cache read path.
module load_extend
    import load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (byte_off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];

        case (opcode)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'd0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// I-type load unit: address generation, memory read handshake, extension and
// register writeback. Optional WAIT watchdog enabled by LOAD_TIMEOUT_EN.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [31:0]       Read_data1,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic              read_enable,
    output logic              reg_write,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              busy,
    output logic              align_fault,
    output logic              timeout_fault
);

    state_t      state;
    logic [5:0]  op_q;
    logic [5:0]  op_in;
    logic [15:0] imm_in;
    logic [31:0] eff_addr;
    logic [31:0] ext_data;
    logic        unused_bits;

    assign op_in    = instruction[OP_MSB:OP_LSB];
    assign imm_in   = instruction[IMM_MSB:IMM_LSB];
    assign eff_addr = Read_data1 + {{16{imm_in[15]}}, imm_in};
    assign busy     = (state != IDLE);

    load_extend u_extend (
        .word     (mem_read_data),
        .byte_off (address[1:0]),
        .opcode   (op_q),
        .result   (ext_data)
    );

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign unused_bits = ^instruction[RS_MSB:RS_LSB];
`else
    assign unused_bits   = ^{instruction[RS_MSB:RS_LSB], TIMEOUT_CYCLES};
    assign timeout_fault = 1'b0;
`endif

    // Fault strobes and reg_write default low so each is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= '0;
            address        <= '0;
            write_reg      <= '0;
            read_enable    <= 1'b0;
            reg_write      <= 1'b0;
            reg_write_data <= '0;
            align_fault    <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            timeout_fault  <= 1'b0;
            wait_cnt       <= '0;
`endif
        end else begin
            reg_write   <= 1'b0;
            align_fault <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            timeout_fault <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (instr_valid && is_load(op_in)) begin
                        address   <= eff_addr[ADDR_W-1:0];
                        write_reg <= instruction[RT_MSB:RT_LSB];
                        op_q      <= op_in;
                        if (is_misaligned(op_in, eff_addr[1:0])) begin
                            state       <= ERR;
                            align_fault <= 1'b1;
                        end else begin
                            state       <= REQ;
                            read_enable <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
                            wait_cnt    <= '0;
`endif
                        end
                    end
                end
                REQ, WAIT: begin
                    if (mem_ready) begin
                        state          <= WB;
                        read_enable    <= 1'b0;
                        reg_write_data <= ext_data;
                        reg_write      <= (write_reg != 5'd0);
`ifdef LOAD_TIMEOUT_EN
                    end else if (int'(wait_cnt) == TIMEOUT_CYCLES - 1) begin
                        state         <= IDLE;
                        read_enable   <= 1'b0;
                        timeout_fault <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`else
                    end else begin
                        state <= WAIT;
                    end
`endif
                end
                WB:      state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vector table, randomized loads
// against a behavioural model, and hand-written reset/ignore sequences.
module tb_load_unit;
    import load_unit_pkg::*;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int MAX_EDGES      = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] Read_data1;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic [31:0] address;
    logic        read_enable;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] reg_write_data;
    logic        busy;
    logic        align_fault;
    logic        timeout_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] base;
        logic [15:0] imm;
        logic [4:0]  rt;
        logic [31:0] word;
        int          delay;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic        exp_timeout;
        logic        poke;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    load_unit #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .Read_data1     (Read_data1),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .address        (address),
        .read_enable    (read_enable),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .reg_write_data (reg_write_data),
        .busy           (busy),
        .align_fault    (align_fault),
        .timeout_fault  (timeout_fault)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Behavioural reference: plain integer arithmetic on the load rules.
    function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [15:0] imm);
        int signed off;
        off = $signed(imm);
        return base + off;
    endfunction

    function automatic int model_size(input logic [5:0] op);
        if (op == OP_LW) return 4;
        if (op == OP_LH || op == OP_LHU) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_data(input logic [5:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint val;
        if (op == OP_LW) return word;
        if (model_size(op) == 1) begin
            val = longint'((word >> (8 * (addr % 4))) % 256);
            if (op == OP_LB && val >= 128) val = val - 256;
        end else begin
            val = longint'((word >> (16 * ((addr % 4) / 2))) % 65536);
            if (op == OP_LH && val >= 32768) val = val - 65536;
        end
        return val[31:0];
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] base, input logic [15:0] imm,
                                input logic [4:0] rt, input logic [31:0] word, input int delay,
                                input logic [31:0] exp_addr, input logic [31:0] exp_data,
                                input logic exp_fault, input logic exp_timeout, input logic poke);
        vec_t v;
        v.op = op; v.base = base; v.imm = imm; v.rt = rt; v.word = word; v.delay = delay;
        v.exp_addr = exp_addr; v.exp_data = exp_data; v.exp_fault = exp_fault;
        v.exp_timeout = exp_timeout; v.poke = poke;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int   edges, re_cnt, waited, wr_cnt, wr_edge, exp_edges, exp_re;
        logic fault_seen, tout_seen, exp_wr;
        logic [31:0] wr_data;
        edges = 0; re_cnt = 0; waited = 0; wr_cnt = 0; wr_edge = -1;
        fault_seen = 1'b0; tout_seen = 1'b0; wr_data = '0;

        instruction = {v.op, 5'($urandom), v.rt, v.imm};
        Read_data1  = v.base;
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        @(posedge clk); #1;
        edges = 1;
        instr_valid = v.poke;
        instruction = {OP_LW, 5'd0, 5'd31, 16'h0000};
        Read_data1  = 32'($urandom);
        checkOutput({tag, " address"}, address, v.exp_addr);
        checkOutput({tag, " write_reg"}, 32'(write_reg), 32'(v.rt));
        checkOutput({tag, " busy_after_accept"}, 32'(busy), 32'd1);

        while (busy && edges < MAX_EDGES) begin
            if (reg_write) begin
                wr_cnt++;
                wr_edge = edges;
                wr_data = reg_write_data;
            end
            fault_seen |= align_fault;
            tout_seen  |= timeout_fault;
            if (read_enable) begin
                re_cnt++;
                mem_ready     = (waited == v.delay);
                mem_read_data = mem_ready ? v.word : 32'($urandom);
                waited++;
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        tout_seen  |= timeout_fault;
        if (reg_write) wr_cnt++;

        exp_edges = v.exp_fault ? 2 : (v.exp_timeout ? TIMEOUT_CYCLES + 1 : 3 + v.delay);
        exp_re    = v.exp_fault ? 0 : (v.exp_timeout ? TIMEOUT_CYCLES : v.delay + 1);
        exp_wr    = !v.exp_fault && !v.exp_timeout && (v.rt != 5'd0);

        checkOutput({tag, " cycles_busy"}, 32'(edges), 32'(exp_edges));
        checkOutput({tag, " read_enable_cycles"}, 32'(re_cnt), 32'(exp_re));
        checkOutput({tag, " reg_write_count"}, 32'(wr_cnt), 32'(exp_wr));
        checkOutput({tag, " align_fault"}, 32'(fault_seen), 32'(v.exp_fault));
        checkOutput({tag, " timeout_fault"}, 32'(tout_seen), 32'(v.exp_timeout));
        if (exp_wr) begin
            checkOutput({tag, " reg_write_data"}, wr_data, v.exp_data);
            checkOutput({tag, " writeback_cycle"}, 32'(wr_edge), 32'(2 + v.delay));
        end
        checkOutput({tag, " address_held"}, address, v.exp_addr);
        checkOutput({tag, " write_reg_held"}, 32'(write_reg), 32'(v.rt));

        @(posedge clk); #1;
        checkOutput({tag, " idle_pulses"}, {28'd0, busy, align_fault, timeout_fault, reg_write}, 32'd0);
    endtask

    initial begin
        int          wr_cnt;
        vec_t        v;
        logic [31:0] a;
        logic [5:0]  ops[5];
        ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU; ops[4] = OP_LHU;

        // Reset wins over a valid load presented at the same time.
        reset = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1;
        instruction = {OP_LW, 5'd1, 5'd3, 16'h0008}; Read_data1 = 32'h100; mem_read_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        checkOutput("reset address", address, 32'd0);
        checkOutput("reset reg_write_data", reg_write_data, 32'd0);
        checkOutput("reset controls",
                    {25'd0, write_reg, read_enable, reg_write, busy, align_fault, timeout_fault}, 32'd0);

        //            op      base          imm       rt     word           dly  addr          data          flt   tout  poke
        vecs.push_back(mk(OP_LW,  32'h0000_0000, 16'h0004, 5'd9,  32'h1234_5678, 0, 32'h0000_0004, 32'h1234_5678, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LB,  32'h0000_001C, 16'h0023, 5'd3,  32'hABCD_EF01, 4, 32'h0000_003F, 32'hFFFF_FFAB, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LBU, 32'h0000_001C, 16'h0023, 5'd4,  32'hABCD_EF01, 4, 32'h0000_003F, 32'h0000_00AB, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LH,  32'h0000_0000, 16'h0006, 5'd5,  32'h8001_BEEF, 1, 32'h0000_0006, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LHU, 32'h0000_0000, 16'h0006, 5'd6,  32'h8001_BEEF, 1, 32'h0000_0006, 32'h0000_8001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LW,  32'h0000_0000, 16'h0002, 5'd7,  32'h0000_0000, 0, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LW,  32'h0000_0040, 16'h0000, 5'd0,  32'hDEAD_BEEF, 0, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LB,  32'h0000_0100, 16'hFFFF, 5'd10, 32'h7F00_0000, 2, 32'h0000_00FF, 32'h0000_007F, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LH,  32'h0000_0010, 16'h0000, 5'd11, 32'h1234_F00D, 0, 32'h0000_0010, 32'hFFFF_F00D, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LH,  32'h0000_0000, 16'h0001, 5'd12, 32'h0000_0000, 0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LHU, 32'h0000_0000, 16'h0003, 5'd13, 32'h0000_0000, 0, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LW,  32'hFFFF_FFFC, 16'h0008, 5'd14, 32'hCAFE_F00D, 3, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_LW,  32'h0000_0200, 16'h0010, 5'd15, 32'h5555_AAAA, 2, 32'h0000_0210, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1));
`ifdef LOAD_TIMEOUT_EN
        vecs.push_back(mk(OP_LW,  32'h0000_0300, 16'h0000, 5'd16, 32'h1111_2222, 100, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_LW,  32'h0000_0304, 16'h0000, 5'd17, 32'h3333_4444, TIMEOUT_CYCLES - 1, 32'h0000_0304, 32'h3333_4444, 1'b0, 1'b0, 1'b0));
`else
        vecs.push_back(mk(OP_LW,  32'h0000_0300, 16'h0000, 5'd16, 32'h1111_2222, 20, 32'h0000_0300, 32'h1111_2222, 1'b0, 1'b0, 1'b0));
`endif

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 40; n++) begin
            v.op    = ops[$urandom_range(0, 4)];
            v.base  = $urandom;
            v.imm   = 16'($urandom);
            v.rt    = 5'($urandom);
            v.word  = $urandom;
            v.delay = $urandom_range(0, 5);
            v.poke  = ($urandom_range(0, 3) == 0);
            a = model_addr(v.base, v.imm);
            if ($urandom_range(0, 3) != 0) v.base = v.base - (a % model_size(v.op));
            v.exp_addr    = model_addr(v.base, v.imm);
            v.exp_fault   = (v.exp_addr % model_size(v.op)) != 0;
            v.exp_data    = model_data(v.op, v.exp_addr, v.word);
            v.exp_timeout = 1'b0;
            applyStimulus(v, $sformatf("rand%0d", n));
        end

        // Reset while stalled in WAIT aborts the load with no writeback.
        instruction = {OP_LW, 5'd0, 5'd12, 16'h0010}; Read_data1 = 32'h0; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stall read_enable", 32'(read_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort address", address, 32'd0);
        checkOutput("abort controls",
                    {25'd0, write_reg, read_enable, reg_write, busy, align_fault, timeout_fault}, 32'd0);
        wr_cnt = 0;
        mem_ready = 1'b1; mem_read_data = 32'h9999_9999;
        repeat (3) begin
            @(posedge clk); #1;
            if (reg_write || busy) wr_cnt++;
        end
        mem_ready = 1'b0;
        checkOutput("abort no_writeback", 32'(wr_cnt), 32'd0);

        // Store and non-load opcodes are not accepted.
        instruction = {OP_SW, 5'd2, 5'd8, 16'h0020}; Read_data1 = 32'h1000; instr_valid = 1'b1;
        @(posedge clk); #1;
        instruction = {6'b000000, 5'd2, 5'd8, 16'h0020};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checkOutput("ignore busy", 32'(busy), 32'd0);
        checkOutput("ignore read_enable", 32'(read_enable), 32'd0);
        checkOutput("ignore address", address, 32'd0);
        checkOutput("ignore write_reg", 32'(write_reg), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
